// File: rtl/bk_add_pkg.sv
// Shared definitions for the shared-adder scheduler: word width, FSM states
// and the id-width helper used to size requester indices.
package bk_add_pkg;

  localparam int ADD_WORD_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/BrentKung32.sv
// 32-bit Brent-Kung prefix adder: out[31:0] = in1 + in2 + c0, out[32] = carry.
// Carry-in is folded into bit 0's generate so the prefix tree yields all carries.
module BrentKung32 (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        c0,
  output logic [32:0] out
);

  logic [31:0] p, g, gp;
  int          hi, lo, d;

  always_comb begin
    p    = in1 ^ in2;
    g    = in1 & in2;
    g[0] = g[0] | (p[0] & c0);
    gp   = p;
    hi   = 0;
    lo   = 0;
    d    = 1;
    // Up-sweep: build group generate/propagate over power-of-two spans.
    for (int lvl = 0; lvl < 5; lvl++) begin
      d = 1 << lvl;
      for (int k = 0; k < (16 >> lvl); k++) begin
        hi     = 2 * d * k + 2 * d - 1;
        lo     = hi - d;
        g[hi]  = g[hi] | (gp[hi] & g[lo]);
        gp[hi] = gp[hi] & gp[lo];
      end
    end
    // Down-sweep: fill in the carries at the remaining positions.
    for (int lvl = 3; lvl >= 0; lvl--) begin
      d = 1 << lvl;
      for (int k = 0; k < (16 >> lvl) - 1; k++) begin
        hi     = 3 * d - 1 + 2 * d * k;
        lo     = hi - d;
        g[hi]  = g[hi] | (gp[hi] & g[lo]);
        gp[hi] = gp[hi] & gp[lo];
      end
    end
    out = {g[31], p ^ {g[30:0], c0}};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the requester at ptr has top priority,
// then ascending indices with wrap. No grant while en is low.
module rr_arbiter
  import bk_add_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  int   j;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && !found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IDW'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bk_add_sched.sv
// Shared-adder scheduler: grants one requester at a time and streams its
// multi-word add/subtract through one BrentKung32, LSW first, carry chained.
// Handshakes: a request transfers on an edge where req_valid[i] && req_ready[i];
// a response transfers on an edge where rsp_valid && rsp_ready, and the
// response fields stay stable while rsp_valid is high and rsp_ready is low.
module bk_add_sched
  import bk_add_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WORDS = 4,
  localparam int W    = ADD_WORD_W * WORDS,
  localparam int IDW  = id_width(NREQ),
  localparam int WIW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic              busy
);

  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WIW-1:0]        word_idx_q, word_idx_d;
  logic                  carry_q, carry_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDW-1:0]        id_q, id_d;
  logic                  cout_q, cout_d, ovf_q, ovf_d;

  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        grant_idx;
  logic [ADD_WORD_W-1:0] add_in1, add_in2;
  logic [ADD_WORD_W:0]   add_out;
  logic                  last_word;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .en        ((state_q == IDLE) && !rst),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign add_in1   = a_q[word_idx_q*ADD_WORD_W +: ADD_WORD_W];
  assign add_in2   = b_q[word_idx_q*ADD_WORD_W +: ADD_WORD_W];
  assign last_word = (word_idx_q == WIW'(WORDS - 1));

  BrentKung32 u_add (
    .in1 (add_in1),
    .in2 (add_in2),
    .c0  (carry_q),
    .out (add_out)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    word_idx_d = word_idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    id_d       = id_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          a_d        = req_a[grant_idx*W +: W];
          b_d        = req_sub[grant_idx] ? ~req_b[grant_idx*W +: W] : req_b[grant_idx*W +: W];
          // Subtract is A + ~B + 1, so the forced carry-in replaces cin.
          carry_d    = req_sub[grant_idx] | req_cin[grant_idx];
          id_d       = grant_idx;
          word_idx_d = '0;
          rr_ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d[word_idx_q*ADD_WORD_W +: ADD_WORD_W] = add_out[ADD_WORD_W-1:0];
        carry_d    = add_out[ADD_WORD_W];
        word_idx_d = word_idx_q + 1'b1;
        if (last_word) begin
          word_idx_d = '0;
          cout_d     = add_out[ADD_WORD_W];
          ovf_d      = (a_q[W-1] == b_q[W-1]) && (add_out[ADD_WORD_W-1] != a_q[W-1]);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      word_idx_q <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      id_q       <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      word_idx_q <= word_idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      id_q       <= id_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule
